map_tile_store: RTL



---
 rtl/map_tile_store.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/map_tile_store.sv
// Tile memory for the map display scanner: 21x21 playfield of 3-bit sprite codes with maze rebuild,
// ready/valid SET/EAT write port and orb tracking. Optional macro: MAP_TILE_STORE_GHOST_HOUSE_EN.
module map_tile_store #(
    parameter int MAP_W = 21,
    parameter int MAP_H = 21
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [4:0] rd_x,
    input  logic [4:0] rd_y,
    output logic [2:0] rd_type,
    input  logic       wr_req,
    input  logic       wr_op,
    input  logic [4:0] wr_x,
    input  logic [4:0] wr_y,
    input  logic [2:0] wr_type,
    output logic       wr_ready,
    output logic       init_done,
    output logic [8:0] orb_count,
    output logic       level_clear,
    output logic       orb_eaten,
    output logic       big_orb_eaten
);

    localparam int DEPTH = MAP_W * MAP_H;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [8:0] ORB_MAX = 9'(DEPTH);

    localparam logic [2:0] T_EMPTY = 3'b000;
    localparam logic [2:0] T_BIG   = 3'b001;
    localparam logic [2:0] T_SMALL = 3'b010;
    localparam logic [2:0] T_WALL  = 3'b011;
    localparam logic [2:0] T_GREY  = 3'b100;

    localparam logic OP_SET = 1'b0;

`ifdef MAP_TILE_STORE_GHOST_HOUSE_EN
    localparam bit GHOST_EN = 1'b1;
`else
    localparam bit GHOST_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_BUSY
    } state_e;

    function automatic logic [2:0] layout(input logic [4:0] x, input logic [4:0] y);
        int xi;
        int yi;
        xi = int'(x);
        yi = int'(y);
        if (xi == 0 || xi == MAP_W - 1 || yi == 0 || yi == MAP_H - 1) return T_WALL;
        if (GHOST_EN && xi >= 9 && xi <= 11 && yi >= 9 && yi <= 11) return T_GREY;
        if ((xi == 1 || xi == MAP_W - 2) && (yi == 1 || yi == MAP_H - 2)) return T_BIG;
        if (!x[0] && !y[0]) return T_WALL;
        return T_SMALL;
    endfunction

    function automatic logic is_orb(input logic [2:0] code);
        return (code == T_BIG) || (code == T_SMALL);
    endfunction

    function automatic logic in_range(input logic [4:0] x, input logic [4:0] y);
        return (int'(x) < MAP_W) && (int'(y) < MAP_H);
    endfunction

    function automatic logic [AW-1:0] tile_idx(input logic [4:0] x, input logic [4:0] y);
        return AW'(y) * AW'(MAP_W) + AW'(x);
    endfunction

    state_e     state_q, state_d;
    logic [4:0] init_x_q, init_x_d;
    logic [4:0] init_y_q, init_y_d;
    logic       op_q, op_d;
    logic [4:0] x_q, x_d;
    logic [4:0] y_q, y_d;
    logic [2:0] type_q, type_d;
    logic [8:0] orb_count_q, orb_count_d;
    logic       orb_eaten_q, orb_eaten_d;
    logic       big_orb_eaten_q, big_orb_eaten_d;

    logic [2:0]    mem_q [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [2:0]    mem_wdata;

    logic          busy_in_range;
    logic [AW-1:0] busy_idx;
    logic [2:0]    old_code;
    logic [2:0]    init_code;
    logic          rd_in_range;
    logic [AW-1:0] rd_idx;

    assign busy_in_range = in_range(x_q, y_q);
    assign busy_idx      = busy_in_range ? tile_idx(x_q, y_q) : '0;
    assign old_code      = mem_q[busy_idx];
    assign init_code     = layout(init_x_q, init_y_q);
    assign rd_in_range   = in_range(rd_x, rd_y);
    assign rd_idx        = rd_in_range ? tile_idx(rd_x, rd_y) : '0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q         <= ST_INIT;
            init_x_q        <= '0;
            init_y_q        <= '0;
            op_q            <= OP_SET;
            x_q             <= '0;
            y_q             <= '0;
            type_q          <= T_EMPTY;
            orb_count_q     <= '0;
            orb_eaten_q     <= 1'b0;
            big_orb_eaten_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            init_x_q        <= init_x_d;
            init_y_q        <= init_y_d;
            op_q            <= op_d;
            x_q             <= x_d;
            y_q             <= y_d;
            type_q          <= type_d;
            orb_count_q     <= orb_count_d;
            orb_eaten_q     <= orb_eaten_d;
            big_orb_eaten_q <= big_orb_eaten_d;
        end
    end

    // Tile storage is not reset; INIT rewrites every entry before reads are enabled.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_d         = state_q;
        init_x_d        = init_x_q;
        init_y_d        = init_y_q;
        op_d            = op_q;
        x_d             = x_q;
        y_d             = y_q;
        type_d          = type_q;
        orb_count_d     = orb_count_q;
        orb_eaten_d     = 1'b0;
        big_orb_eaten_d = 1'b0;
        mem_we          = 1'b0;
        mem_waddr       = '0;
        mem_wdata       = T_EMPTY;

        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = tile_idx(init_x_q, init_y_q);
                mem_wdata = init_code;
                if (is_orb(init_code) && orb_count_q != ORB_MAX) begin
                    orb_count_d = orb_count_q + 9'd1;
                end
                if (int'(init_x_q) == MAP_W - 1) begin
                    init_x_d = '0;
                    if (int'(init_y_q) == MAP_H - 1) begin
                        state_d = ST_IDLE;
                    end else begin
                        init_y_d = init_y_q + 5'd1;
                    end
                end else begin
                    init_x_d = init_x_q + 5'd1;
                end
            end
            ST_IDLE: begin
                if (wr_req) begin
                    op_d    = wr_op;
                    x_d     = wr_x;
                    y_d     = wr_y;
                    type_d  = wr_type;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                state_d = ST_IDLE;
                if (busy_in_range) begin
                    if (op_q == OP_SET) begin
                        mem_we    = 1'b1;
                        mem_waddr = busy_idx;
                        mem_wdata = type_q;
                        if (is_orb(old_code) && !is_orb(type_q) && orb_count_q != 9'd0) begin
                            orb_count_d = orb_count_q - 9'd1;
                        end else if (!is_orb(old_code) && is_orb(type_q) && orb_count_q != ORB_MAX) begin
                            orb_count_d = orb_count_q + 9'd1;
                        end
                    end else if (is_orb(old_code)) begin
                        mem_we          = 1'b1;
                        mem_waddr       = busy_idx;
                        mem_wdata       = T_EMPTY;
                        orb_eaten_d     = 1'b1;
                        big_orb_eaten_d = (old_code == T_BIG);
                        if (orb_count_q != 9'd0) begin
                            orb_count_d = orb_count_q - 9'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // A reset edge must not commit an in-flight write.
        if (!resetn) begin
            mem_we = 1'b0;
        end
    end

    always_comb begin
        wr_ready      = (state_q == ST_IDLE);
        init_done     = (state_q != ST_INIT);
        orb_count     = orb_count_q;
        level_clear   = (state_q != ST_INIT) && (orb_count_q == 9'd0);
        orb_eaten     = orb_eaten_q;
        big_orb_eaten = big_orb_eaten_q;
        rd_type       = ((state_q != ST_INIT) && rd_in_range) ? mem_q[rd_idx] : T_EMPTY;
    end

endmodule
